dmem_access_arbiter: RTL and testbench
======================================

Name: dmem_access_arbiter

Overview:
Sequences and shares the byte-addressed, big-endian data memory (8-bit address, 32-bit data, Size/RW/E control) between two requesters. Requester 0 is the pipeline MEM stage; requester 1 is the program loader/debug port. The arbiter registers each request, drives the memory control for exactly one access cycle, and returns a one-cycle response. It guarantees that the memory write enable is never asserted outside a controlled access cycle.

Parameters:
ADDR_W, 8, memory address width (256 bytes)
DATA_W, 32, data width
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
r0_req  in  1  requester 0 access request; held until r0_gnt
r0_addr  in  ADDR_W  requester 0 byte address
r0_wdata  in  DATA_W  requester 0 write data (right-justified for byte/half)
r0_size  in  2  00 byte, 01 halfword, 10 word
r0_rw  in  1  0 read, 1 write
r0_gnt  out  1  request accepted this cycle
r0_rsp_valid  out  1  one-cycle response pulse
r1_req, r1_addr, r1_wdata, r1_size, r1_rw, r1_gnt, r1_rsp_valid: same as requester 0
rsp_rdata  out  DATA_W  read data, valid with either rsp_valid
rsp_err  out  1  access rejected (only with optional feature; else 0)
mem_a  out  ADDR_W  to memory A
mem_di  out  DATA_W  to memory DI
mem_size  out  2  to memory Size
mem_rw  out  1  to memory RW
mem_e  out  1  to memory E
mem_do  in  DATA_W  from memory DO (combinational read)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset: state IDLE, all gnt/rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_a 0, mem_di 0, mem_size 10, mem_rw 0, mem_e 0, rr pointer = requester 0 has priority next.
- IDLE: gnt is combinational from req and arbitration; at most one gnt high. An edge with rN_req & rN_gnt latches addr/wdata/size/rw into internal registers, records the owner, and moves to ACCESS.
- Arbitration: FIXED_PRIO=1 -> r0 wins. FIXED_PRIO=0 -> on a conflict, the requester not granted last wins; a single requester is always granted. The pointer updates only on grant.
- ACCESS (one cycle): mem_a/mem_di/mem_size/mem_rw driven from the latched registers, stable for the whole cycle. mem_e = latched rw (writes only). For reads, mem_do is captured into rsp_rdata at the closing edge. For writes, rsp_rdata holds its previous value. Next state is RESP.
- RESP (one cycle): the owner's rsp_valid = 1. mem_rw = 0 and mem_e = 0. gnt stays low. Next state is IDLE.
- Latency: grant edge k -> rsp_valid high in cycle k+2. Maximum throughput is one access per 3 cycles.
- Outside ACCESS, mem_rw = 0 and mem_e = 0, because the memory writes combinationally. mem_a/di/size keep their last values.
- Byte data is right-justified, e.g. byte read returns {24'b0, byte}. Addresses wrap mod 256, so a word at 0xFE touches 0xFE, 0xFF, 0x00, 0x01; the arbiter passes this through unchanged.
- A request dropped before grant is ignored. A request changed while waiting is treated as the new request.
- Reset asserted mid-ACCESS forces mem_e and mem_rw to 0 immediately and returns the FSM to IDLE. No rsp_valid is issued. Memory contents at the target address are then undefined.

Optional Feature:
Macro DMEM_ALIGN_CHECK_EN.
- Defined: a latched request is rejected if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
  - A rejected request still passes through ACCESS, but mem_e and mem_rw are forced to 0.
  - In RESP: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Accepted accesses give rsp_err=0.
- Undefined: all requests are forwarded and rsp_err is tied to 0. size=11 reaches the memory as-is: a read returns 0 and a write has no effect.

Decomposition:
- Package dmem_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD codes, RW_READ/RW_WRITE, FSM state encoding, misalignment function.
- Sub-module rr_arbiter2: 2-way round-robin/fixed-priority grant with pointer register.

Test Plan:
- Reset values: assert reset with r0_req=1 -> all outputs at reset values, mem_e=0 throughout, no gnt.
- r0 word write: addr 0x10, data 0xDEADBEEF, then r0 read of the same word.
  - Write: mem_e high exactly one cycle; rsp_valid at k+2.
  - Read: rsp_rdata=0xDEADBEEF.
  - Byte read at 0x11 returns 0x000000AD.
- Simultaneous requests, FIXED_PRIO=0, both held for 4 accesses -> grant order r0, r1, r0, r1. With FIXED_PRIO=1 -> r0 granted every time while requesting.
- Wrap-around: word write 0x11223344 at 0xFE -> bytes 0xFE=11, 0xFF=22, 0x00=33, 0x01=44.
- DMEM_ALIGN_CHECK_EN on: half write at 0x03 -> mem_e never high, rsp_err=1, rsp_rdata=0, memory unchanged. Feature off: same request writes 0x03/0x04.
- Reset asserted during the ACCESS cycle of a write -> mem_e drops asynchronously, no rsp_valid, FSM back in IDLE, next request granted normally.

Source files
------------

// File: rtl/dmem_access_arbiter_pkg.sv
// Shared codes, FSM encoding and alignment helper for the data-memory arbiter.
// DMEM_ALIGN_CHECK_EN (optional) enables rejection of misaligned accesses.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Size 11 is never a legal access width.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a_lo
  );
    logic bad;
    bad = 1'b0;
    unique case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = a_lo[0];
      SIZE_WORD: bad = |a_lo;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// Requester and memory-side signal bundle of the data-memory arbiter.
// The slave modport is the arbiter; the master modport is the surroundings.
interface dmem_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              r0_req;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [1:0]        r0_size;
  logic              r0_rw;
  logic              r0_gnt;
  logic              r0_rsp_valid;

  logic              r1_req;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic [1:0]        r1_size;
  logic              r1_rw;
  logic              r1_gnt;
  logic              r1_rsp_valid;

  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_di;
  logic [1:0]        mem_size;
  logic              mem_rw;
  logic              mem_e;
  logic [DATA_W-1:0] mem_do;

  modport slave (
    input  r0_req, r0_addr, r0_wdata,
    input  r0_size, r0_rw,
    output r0_gnt, r0_rsp_valid,
    input  r1_req, r1_addr, r1_wdata,
    input  r1_size, r1_rw,
    output r1_gnt, r1_rsp_valid,
    output rsp_rdata, rsp_err,
    output mem_a, mem_di, mem_size,
    output mem_rw, mem_e,
    input  mem_do
  );

  modport master (
    output r0_req, r0_addr, r0_wdata,
    output r0_size, r0_rw,
    input  r0_gnt, r0_rsp_valid,
    output r1_req, r1_addr, r1_wdata,
    output r1_size, r1_rw,
    input  r1_gnt, r1_rsp_valid,
    input  rsp_rdata, rsp_err,
    input  mem_a, mem_di, mem_size,
    input  mem_rw, mem_e,
    output mem_do
  );

endinterface

// File: rtl/dmem_access_arbiter_rr_arbiter2.sv
// Two-way grant logic: round-robin on conflict, or fixed priority to
// requester 0 when FIXED_PRIO is nonzero.
module rr_arbiter2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Set when requester 1 won last, so requester 0 goes first.
  logic r_last;
  logic w_r0_first;

  assign w_r0_first = (FIXED_PRIO != 0) || r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      unique case (1'b1)
        (i_req == 2'b11):
          o_gnt = w_r0_first ? 2'b01 : 2'b10;
        (i_req == 2'b01): o_gnt = 2'b01;
        (i_req == 2'b10): o_gnt = 2'b10;
        default:          o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (|o_gnt) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the big-endian data memory between the MEM stage and the loader.
// DMEM_ALIGN_CHECK_EN: misaligned/illegal-size requests are rejected.
module dmem_access_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input logic                  clk,
  input logic                  reset,
  dmem_access_arbiter_if.slave bus
);

  state_t r_state;
  state_t w_next;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_arb_en;
  logic              w_take;
  logic              w_sel;
  logic              w_rej;
  logic              w_is_acc;
  logic              w_is_rsp;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_size;
  logic              w_rw;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_size;
  logic              r_rw;
  logic              r_owner;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  assign w_req    = {bus.r1_req, bus.r0_req};
  assign w_arb_en = (r_state == ST_IDLE) && !reset;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_arb_en),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign w_take = |w_gnt;
  assign w_sel  = w_gnt[1];

  always_comb begin
    w_addr  = bus.r0_addr;
    w_wdata = bus.r0_wdata;
    w_size  = bus.r0_size;
    w_rw    = bus.r0_rw;
    if (w_sel) begin
      w_addr  = bus.r1_addr;
      w_wdata = bus.r1_wdata;
      w_size  = bus.r1_size;
      w_rw    = bus.r1_rw;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_rej = misaligned(w_size, w_addr[1:0]);
`else
  assign w_rej = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_take) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= SIZE_WORD;
      r_rw    <= RW_READ;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_take) begin
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_size  <= w_size;
      r_rw    <= w_rw;
      r_owner <= w_sel;
      r_err   <= w_rej;
    end
  end

  // Writes leave the last read data in place; rejects return zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (r_state == ST_ACCESS) begin
      if (r_err) begin
        r_rdata <= '0;
      end else if (r_rw == RW_READ) begin
        r_rdata <= bus.mem_do;
      end
    end
  end

  assign w_is_acc = (r_state == ST_ACCESS);
  assign w_is_rsp = (r_state == ST_RESP);

  // The memory writes combinationally: strobe only in ACCESS.
  assign bus.mem_a    = r_addr;
  assign bus.mem_di   = r_wdata;
  assign bus.mem_size = r_size;
  assign bus.mem_rw   = w_is_acc & r_rw & ~r_err;
  assign bus.mem_e    = w_is_acc & r_rw & ~r_err;

  assign bus.r0_gnt       = w_gnt[0];
  assign bus.r1_gnt       = w_gnt[1];
  assign bus.r0_rsp_valid = w_is_rsp & ~r_owner;
  assign bus.r1_rsp_valid = w_is_rsp & r_owner;
  assign bus.rsp_rdata    = r_rdata;
  assign bus.rsp_err      = w_is_rsp & r_err;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: directed requests, big-endian memory model,
// queue scoreboard popped whenever a response pulse appears.
module tb_dmem_access_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_access_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  dmem_access_arbiter_if #(.ADDR_W(8), .DATA_W(32)) fbus ();

  dmem_access_arbiter #(
    .ADDR_W(8), .DATA_W(32), .FIXED_PRIO(0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  dmem_access_arbiter #(
    .ADDR_W(8), .DATA_W(32), .FIXED_PRIO(1)
  ) dut_fp (
    .clk(clk), .reset(reset), .bus(fbus)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Big-endian byte memory, combinational read
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ma1, ma2, ma3;
  assign ma1 = bus.mem_a + 8'd1;
  assign ma2 = bus.mem_a + 8'd2;
  assign ma3 = bus.mem_a + 8'd3;

  always_comb begin
    case (bus.mem_size)
      2'b00: bus.mem_do = {24'h0, mem[bus.mem_a]};
      2'b01: bus.mem_do = {16'h0, mem[bus.mem_a], mem[ma1]};
      2'b10: bus.mem_do = {mem[bus.mem_a], mem[ma1],
                           mem[ma2], mem[ma3]};
      default: bus.mem_do = 32'h0;
    endcase
  end

  always @(negedge clk) begin
    if (bus.mem_e && bus.mem_rw) begin
      case (bus.mem_size)
        2'b00: mem[bus.mem_a] <= bus.mem_di[7:0];
        2'b01: begin
          mem[bus.mem_a] <= bus.mem_di[15:8];
          mem[ma1]       <= bus.mem_di[7:0];
        end
        2'b10: begin
          mem[bus.mem_a] <= bus.mem_di[31:24];
          mem[ma1]       <= bus.mem_di[23:16];
          mem[ma2]       <= bus.mem_di[15:8];
          mem[ma3]       <= bus.mem_di[7:0];
        end
        default: ;
      endcase
    end
  end

  assign fbus.mem_do = 32'h0;

  typedef struct packed {
    logic        who;
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  rsp_t sbq[$];
  rsp_t mon_e;
  int   e_cnt = 0;
  logic [31:0] last_rd = 32'h0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_e) e_cnt++;
      if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
        chk("rsp_onehot",
            {31'h0, bus.r0_rsp_valid & bus.r1_rsp_valid}, 32'h0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got r0=%0b r1=%0b expected none",
                   bus.r0_rsp_valid, bus.r1_rsp_valid);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_owner", {31'h0, bus.r1_rsp_valid}, {31'h0, mon_e.who});
          chk("rsp_rdata", bus.rsp_rdata, mon_e.rd);
          chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, mon_e.err});
        end
      end
    end
  end

  int f_g0 = 0;
  int f_g1 = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (fbus.r0_gnt) f_g0++;
      if (fbus.r1_gnt) f_g1++;
    end
  end

  task automatic drive(input logic who, input logic req,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic rw);
    if (who) begin
      bus.r1_req = req; bus.r1_addr = a; bus.r1_wdata = d;
      bus.r1_size = sz; bus.r1_rw = rw;
    end else begin
      bus.r0_req = req; bus.r0_addr = a; bus.r0_wdata = d;
      bus.r0_size = sz; bus.r0_rw = rw;
    end
  endtask

  task automatic access(input logic who, input logic [7:0] a,
                        input logic [31:0] d, input logic [1:0] sz,
                        input logic rw, input logic [31:0] rd_exp,
                        input logic err_exp);
    logic g;
    rsp_t e;
    @(negedge clk);
    drive(who, 1'b1, a, d, sz, rw);
    g = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if ((who ? bus.r1_gnt : bus.r0_gnt) === 1'b1) begin
        g = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!g) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: requester %0d got no grant", who);
      drive(who, 1'b0, a, d, sz, rw);
      return;
    end
    e.who = who;
    e.err = err_exp;
    e.rd  = err_exp ? 32'h0 : (rw ? last_rd : rd_exp);
    last_rd = e.rd;
    sbq.push_back(e);
    @(posedge clk);
    #1 drive(who, 1'b0, a, d, sz, rw);
    @(negedge clk);
    chk("acc_mem_a", {24'h0, bus.mem_a}, {24'h0, a});
    chk("acc_mem_e", {31'h0, bus.mem_e}, {31'h0, rw & ~err_exp});
    chk("acc_mem_rw", {31'h0, bus.mem_rw}, {31'h0, rw & ~err_exp});
    @(negedge clk);
    chk("rsp_latency",
        {31'h0, who ? bus.r1_rsp_valid : bus.r0_rsp_valid}, 32'h1);
    chk("rsp_mem_e_low", {31'h0, bus.mem_e}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int e0;
  int got;
  logic [3:0] ord;
  rsp_t se;

  initial begin
    drive(1'b0, 1'b0, 8'h0, 32'h0, SIZE_WORD, RW_READ);
    drive(1'b1, 1'b0, 8'h0, 32'h0, SIZE_WORD, RW_READ);
    fbus.r0_req = 1'b0; fbus.r0_addr = 8'h0; fbus.r0_wdata = 32'h0;
    fbus.r0_size = SIZE_WORD; fbus.r0_rw = RW_READ;
    fbus.r1_req = 1'b0; fbus.r1_addr = 8'h4; fbus.r1_wdata = 32'h0;
    fbus.r1_size = SIZE_WORD; fbus.r1_rw = RW_READ;

    // Reset with a pending write request
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'h44, 32'h12345678, SIZE_WORD, RW_WRITE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_gnt0", {31'h0, bus.r0_gnt}, 32'h0);
      chk("rst_mem_e", {31'h0, bus.mem_e}, 32'h0);
    end
    chk("rst_gnt1", {31'h0, bus.r1_gnt}, 32'h0);
    chk("rst_rsp0", {31'h0, bus.r0_rsp_valid}, 32'h0);
    chk("rst_rsp1", {31'h0, bus.r1_rsp_valid}, 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_err", {31'h0, bus.rsp_err}, 32'h0);
    chk("rst_mem_a", {24'h0, bus.mem_a}, 32'h0);
    chk("rst_mem_di", bus.mem_di, 32'h0);
    chk("rst_mem_size", {30'h0, bus.mem_size}, 32'h2);
    chk("rst_mem_rw", {31'h0, bus.mem_rw}, 32'h0);
    drive(1'b0, 1'b0, 8'h0, 32'h0, SIZE_WORD, RW_READ);
    @(negedge clk);
    reset = 1'b0;
    fbus.r0_req = 1'b1;
    fbus.r1_req = 1'b1;

    // Word write then reads
    e0 = e_cnt;
    access(1'b0, 8'h10, 32'hDEADBEEF, SIZE_WORD, RW_WRITE, 32'h0, 1'b0);
    chk("wr_e_pulse", e_cnt - e0, 32'h1);
    chk("wr_mem", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]},
        32'hDEADBEEF);
    access(1'b0, 8'h10, 32'h0, SIZE_WORD, RW_READ, 32'hDEADBEEF, 1'b0);
    access(1'b0, 8'h11, 32'h0, SIZE_BYTE, RW_READ, 32'h000000AD, 1'b0);
    access(1'b1, 8'h12, 32'h0, SIZE_HALF, RW_READ, 32'h0000BEEF, 1'b0);

    // Both held: r1 won last, so order is r0, r1, r0, r1
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h10, 32'h0, SIZE_WORD, RW_READ);
    drive(1'b1, 1'b1, 8'h13, 32'h0, SIZE_BYTE, RW_READ);
    got = 0;
    ord = 4'h0;
    for (int n = 0; n < 40 && got < 4; n++) begin
      #1;
      if (bus.r0_gnt || bus.r1_gnt) begin
        chk("sim_gnt_onehot", {31'h0, bus.r0_gnt & bus.r1_gnt}, 32'h0);
        se.who = bus.r1_gnt;
        se.rd  = bus.r1_gnt ? 32'h000000EF : 32'hDEADBEEF;
        se.err = 1'b0;
        sbq.push_back(se);
        ord[got] = bus.r1_gnt;
        got++;
      end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 8'h0, 32'h0, SIZE_WORD, RW_READ);
    drive(1'b1, 1'b0, 8'h0, 32'h0, SIZE_WORD, RW_READ);
    chk("sim_count", got, 32'd4);
    chk("sim_order", {28'h0, ord}, 32'hA);
    last_rd = 32'h000000EF;
    repeat (3) @(negedge clk);

    // Word write wrapping past the top of memory
    access(1'b0, 8'hFE, 32'h11223344, SIZE_WORD, RW_WRITE, 32'h0, 1'b0);
    chk("wrap_fe", {24'h0, mem[8'hFE]}, 32'h11);
    chk("wrap_ff", {24'h0, mem[8'hFF]}, 32'h22);
    chk("wrap_00", {24'h0, mem[8'h00]}, 32'h33);
    chk("wrap_01", {24'h0, mem[8'h01]}, 32'h44);
    access(1'b1, 8'h00, 32'h0, SIZE_BYTE, RW_READ, 32'h00000033, 1'b0);
    access(1'b0, 8'hFE, 32'h0, SIZE_HALF, RW_READ, 32'h00001122, 1'b0);

    // Misaligned halfword write
    e0 = e_cnt;
`ifdef DMEM_ALIGN_CHECK_EN
    access(1'b0, 8'h03, 32'h0000A5B6, SIZE_HALF, RW_WRITE, 32'h0, 1'b1);
    chk("mis_e_pulse", e_cnt - e0, 32'h0);
    chk("mis_mem3", {24'h0, mem[8'h03]}, 32'h00);
    chk("mis_mem4", {24'h0, mem[8'h04]}, 32'h00);
`else
    access(1'b0, 8'h03, 32'h0000A5B6, SIZE_HALF, RW_WRITE, 32'h0, 1'b0);
    chk("mis_e_pulse", e_cnt - e0, 32'h1);
    chk("mis_mem3", {24'h0, mem[8'h03]}, 32'hA5);
    chk("mis_mem4", {24'h0, mem[8'h04]}, 32'hB6);
`endif

    // Reset in the middle of a write's ACCESS cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h20, 32'hCAFEF00D, SIZE_WORD, RW_WRITE);
    #1 chk("abort_gnt", {31'h0, bus.r0_gnt}, 32'h1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 8'h0, 32'h0, SIZE_WORD, RW_READ);
    #1 chk("abort_pre_e", {31'h0, bus.mem_e}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_mem_e", {31'h0, bus.mem_e}, 32'h0);
    chk("abort_mem_rw", {31'h0, bus.mem_rw}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_rd = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp",
          {31'h0, bus.r0_rsp_valid | bus.r1_rsp_valid}, 32'h0);
    end
    access(1'b1, 8'h10, 32'h0, SIZE_BYTE, RW_READ, 32'h000000DE, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'h0);
    chk("fp_r1_never", f_g1, 32'h0);
    chk("fp_r0_granted", {31'h0, f_g0 > 10}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
